// File: rtl/fsm_control_param.sv
// fsm_control_param: supervises NUM_FIFOS FIFOs, latches/validates thresholds and tracks idle/active/error status.
module fsm_control_param #(
  parameter int NUM_FIFOS = 5,
  parameter int THR_W     = 4,
  parameter int IDLE_DLY  = 2,
  parameter int ID_W      = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         init,
  input  logic [NUM_FIFOS*2*THR_W-1:0] thr_in,
  input  logic [NUM_FIFOS-1:0]         fifo_empty,
  input  logic [NUM_FIFOS-1:0]         fifo_error,
  output logic [NUM_FIFOS*2*THR_W-1:0] thr_out,
  output logic                         idle_out,
  output logic                         active_out,
  output logic [NUM_FIFOS-1:0]         error_out,
  output logic [ID_W-1:0]              err_id,
  output logic                         cfg_err,
  output logic [2:0]                   state_out
);
  localparam int TW = NUM_FIFOS*2*THR_W;
  typedef enum logic [2:0] {S_RESET = 3'd0, S_INIT = 3'd1, S_IDLE = 3'd2, S_ACTIVE = 3'd3, S_ERROR = 3'd4} state_t;
  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [TW-1:0]         thr_q;
  logic                  idle_q, active_q, cfg_err_q;
  logic [NUM_FIFOS-1:0]  err_q;
  logic [ID_W-1:0]       id_q;
  logic                  all_empty;
  function automatic logic thr_bad(input logic [TW-1:0] t);
    logic b;
    b = 1'b0;
    for (int i = 0; i < NUM_FIFOS; i++)
      if (t[2*i*THR_W +: THR_W] >= t[(2*i+1)*THR_W +: THR_W]) b = 1'b1;
    return b;
  endfunction
  function automatic logic [ID_W-1:0] low_id(input logic [NUM_FIFOS-1:0] e);
    logic [ID_W-1:0] id;
    id = '0;
    for (int i = NUM_FIFOS-1; i >= 0; i--)
      if (e[i]) id = ID_W'(i);
    return id;
  endfunction
  assign all_empty = &fifo_empty;
  // The reset-time all-zero thr_q fails validation, so INIT waits for a real capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    if (state_q == S_RESET) state_d = S_INIT;
    else if (init) state_d = S_INIT;
    else if (|fifo_error) state_d = S_ERROR;
    else case (state_q)
      S_INIT:   if (!thr_bad(thr_q)) state_d = all_empty ? S_IDLE : S_ACTIVE;
      S_IDLE:   if (!all_empty) state_d = S_ACTIVE;
      S_ACTIVE: if (all_empty) begin
        if (cnt_q >= 4'(IDLE_DLY-1)) state_d = S_IDLE;
        else cnt_d = cnt_q + 4'd1;
      end
      S_ERROR:  ;
      default:  state_d = S_RESET;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_RESET;
      cnt_q     <= '0;
      thr_q     <= '0;
      idle_q    <= 1'b0;
      active_q  <= 1'b0;
      cfg_err_q <= 1'b0;
      err_q     <= '0;
      id_q      <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idle_q   <= state_d == S_IDLE;
      active_q <= state_d == S_ACTIVE;
      if (init && state_q != S_RESET) begin
        thr_q     <= thr_in;
        cfg_err_q <= thr_bad(thr_in);
        err_q     <= '0;
        id_q      <= '0;
      end else if (state_d == S_ERROR) begin
        err_q <= err_q | fifo_error;
        if (state_q != S_ERROR) id_q <= low_id(fifo_error);
      end
    end
  end
  assign state_out  = state_q;
  assign thr_out    = thr_q;
  assign idle_out   = idle_q;
  assign active_out = active_q;
  assign error_out  = err_q;
  assign err_id     = id_q;
  assign cfg_err    = cfg_err_q;
endmodule

// File: tb/tb_fsm_control_param.sv
// tb_fsm_control_param: directed vectors with hand-computed expectations for fsm_control_param.
module tb_fsm_control_param;
  logic        clk = 1'b0;
  logic        reset, init;
  logic [39:0] thr_in, thr_out;
  logic [4:0]  fifo_empty, fifo_error, error_out;
  logic        idle_out, active_out, cfg_err;
  logic [2:0]  err_id, state_out;
  int          n_vec = 0, n_bad = 0;
  localparam logic [39:0] THR_A = 40'h3131313131;
  localparam logic [39:0] THR_B = 40'h31314C3131;
  localparam logic [39:0] THR_C = 40'h3131C43131;
  fsm_control_param dut (
    .clk(clk), .reset(reset), .init(init), .thr_in(thr_in),
    .fifo_empty(fifo_empty), .fifo_error(fifo_error), .thr_out(thr_out),
    .idle_out(idle_out), .active_out(active_out), .error_out(error_out),
    .err_id(err_id), .cfg_err(cfg_err), .state_out(state_out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_st(input string tag, input logic [2:0] st, input logic idl, input logic act);
    chk({tag, ".state"}, 64'(state_out), 64'(st));
    chk({tag, ".idle"}, 64'(idle_out), 64'(idl));
    chk({tag, ".active"}, 64'(active_out), 64'(act));
  endtask
  initial begin
    reset = 1'b0; init = 1'b0; thr_in = '0; fifo_empty = '0; fifo_error = '0;
    step(); step();
    chk_st("rst", 3'd0, 1'b0, 1'b0);
    chk("rst.thr", 64'(thr_out), 64'h0);
    chk("rst.err", 64'(error_out), 64'h0);
    chk("rst.id", 64'(err_id), 64'h0);
    chk("rst.cfg", 64'(cfg_err), 64'h0);
    reset = 1'b1;
    step();
    chk_st("init0", 3'd1, 1'b0, 1'b0);
    step();
    chk_st("init_hold", 3'd1, 1'b0, 1'b0);
    chk("init_hold.thr", 64'(thr_out), 64'h0);
    chk("init_hold.cfg", 64'(cfg_err), 64'h0);
    init = 1'b1; thr_in = THR_A; fifo_empty = 5'h1f;
    step();
    chk_st("capA", 3'd1, 1'b0, 1'b0);
    chk("capA.thr", 64'(thr_out), 64'(THR_A));
    chk("capA.cfg", 64'(cfg_err), 64'h0);
    init = 1'b0;
    step();
    chk_st("idleA", 3'd2, 1'b1, 1'b0);
    init = 1'b1; thr_in = THR_B;
    step();
    chk_st("capB", 3'd1, 1'b0, 1'b0);
    chk("capB.thr", 64'(thr_out), 64'(THR_B));
    chk("capB.cfg", 64'(cfg_err), 64'h1);
    init = 1'b0;
    step();
    chk_st("badB", 3'd1, 1'b0, 1'b0);
    chk("badB.cfg", 64'(cfg_err), 64'h1);
    init = 1'b1; thr_in = THR_C;
    step();
    chk("capC.cfg", 64'(cfg_err), 64'h0);
    chk("capC.thr", 64'(thr_out), 64'(THR_C));
    init = 1'b0;
    step();
    chk_st("idleC", 3'd2, 1'b1, 1'b0);
    fifo_empty = 5'b11011;
    step();
    chk_st("act", 3'd3, 1'b0, 1'b1);
    fifo_empty = 5'h1f;
    step();
    chk_st("hyst1", 3'd3, 1'b0, 1'b1);
    fifo_empty = 5'b11011;
    step();
    chk_st("hyst_int", 3'd3, 1'b0, 1'b1);
    fifo_empty = 5'h1f;
    step();
    chk_st("hyst_re1", 3'd3, 1'b0, 1'b1);
    step();
    chk_st("hyst_done", 3'd2, 1'b1, 1'b0);
    fifo_empty = 5'b11011;
    step();
    chk_st("act2", 3'd3, 1'b0, 1'b1);
    fifo_error = 5'b10100;
    step();
    chk_st("err", 3'd4, 1'b0, 1'b0);
    chk("err.vec", 64'(error_out), 64'h14);
    chk("err.id", 64'(err_id), 64'd2);
    fifo_error = 5'b00001;
    step();
    chk_st("err2", 3'd4, 1'b0, 1'b0);
    chk("err2.vec", 64'(error_out), 64'h15);
    chk("err2.id", 64'(err_id), 64'd2);
    fifo_error = '0; fifo_empty = 5'h1f;
    step();
    chk_st("err_abs", 3'd4, 1'b0, 1'b0);
    chk("err_abs.thr", 64'(thr_out), 64'(THR_C));
    init = 1'b1;
    step();
    chk_st("err_init", 3'd1, 1'b0, 1'b0);
    chk("err_init.vec", 64'(error_out), 64'h0);
    chk("err_init.id", 64'(err_id), 64'h0);
    init = 1'b0;
    step();
    chk_st("idleD", 3'd2, 1'b1, 1'b0);
    fifo_empty = '0;
    step();
    chk_st("act3", 3'd3, 1'b0, 1'b1);
    reset = 1'b0;
    step();
    chk_st("midrst", 3'd0, 1'b0, 1'b0);
    chk("midrst.thr", 64'(thr_out), 64'h0);
    reset = 1'b1;
    step();
    chk_st("midrst_init", 3'd1, 1'b0, 1'b0);
    fifo_error = 5'b01000;
    step();
    chk_st("init_err", 3'd4, 1'b0, 1'b0);
    chk("init_err.vec", 64'(error_out), 64'h08);
    chk("init_err.id", 64'(err_id), 64'd3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
